// File: rtl/nn_upscale_stream.sv
// Streaming nearest-neighbour upscaler for 24-bit RGB: live lines are replicated horizontally
// as they arrive, then replayed SCALE_Y-1 times from a single line buffer.
module nn_upscale_stream #(
    parameter int unsigned WIDTH   = 768,
    parameter int unsigned HEIGHT  = 512,
    parameter int unsigned SCALE_X = 2,
    parameter int unsigned SCALE_Y = 2,
    parameter int unsigned DW      = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] r,
    input  logic [DW-1:0] g,
    input  logic [DW-1:0] b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_r,
    output logic [DW-1:0] out_g,
    output logic [DW-1:0] out_b,
    output logic          out_sol,
    output logic          out_eol,
    output logic          out_eof,
    output logic          done,
    output logic [15:0]   frame_cnt
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned XW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
    localparam int unsigned YW = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;
    localparam int unsigned PW = 3 * DW;

    localparam logic [CW-1:0] ColLast = CW'(WIDTH - 1);
    localparam logic [RW-1:0] RowLast = RW'(HEIGHT - 1);
    localparam logic [XW-1:0] XLast   = XW'(SCALE_X - 1);
    localparam logic [YW-1:0] YLast   = YW'(SCALE_Y - 1);

    typedef enum logic [1:0] {StLive, StReplay, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   col_q, col_d, raddr;
    logic [RW-1:0]   row_q, row_d;
    logic [XW-1:0]   xrep_q, xrep_d;
    logic [YW-1:0]   yrep_q, yrep_d;
    logic            vld_q, vld_d;
    logic [PW-1:0]   pix_q, pix_d;
    logic            done_q;
    logic [15:0]     fcnt_q, fcnt_d;
    logic [PW-1:0]   rd_q;
    logic [PW-1:0]   linebuf_q [WIDTH];

    logic x_last, eol, y_last, r_last, out_hs, in_hs, line_end, live_stays;

    assign x_last     = (xrep_q == XLast);
    assign eol        = (col_q == ColLast) && x_last;
    assign y_last     = (yrep_q == YLast);
    assign r_last     = (row_q == RowLast);
    assign out_hs     = vld_q && out_ready;
    assign line_end   = out_hs && eol;
    // A live line end only admits the next pixel when no replay and no frame end follows
    assign live_stays = y_last && !r_last;
    assign in_ready   = !reset && (state_q == StLive) &&
                        (!vld_q || (out_ready && x_last && (!eol || live_stays)));
    assign in_hs      = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        xrep_d  = xrep_q;
        yrep_d  = yrep_q;
        vld_d   = vld_q;
        pix_d   = pix_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            StLive: begin
                if (out_hs) begin
                    if (!x_last) begin
                        xrep_d = xrep_q + 1'b1;
                    end else begin
                        vld_d  = 1'b0;
                        xrep_d = '0;
                        if (!eol) col_d = col_q + 1'b1;
                    end
                end
                if (in_hs) begin
                    vld_d  = 1'b1;
                    xrep_d = '0;
                    pix_d  = {r, g, b};
                end
            end
            StReplay: begin
                if (!vld_q) begin
                    // Bubble at the start of a replay line while the first read lands
                    vld_d = 1'b1;
                    pix_d = rd_q;
                end else if (out_hs) begin
                    if (!x_last) begin
                        xrep_d = xrep_q + 1'b1;
                    end else if (!eol) begin
                        xrep_d = '0;
                        col_d  = col_q + 1'b1;
                        pix_d  = rd_q;
                    end else begin
                        xrep_d = '0;
                        vld_d  = 1'b0;
                    end
                end
            end
            StDone: begin
                fcnt_d  = fcnt_q + 16'd1;
                state_d = StLive;
            end
            default: state_d = StLive;
        endcase
        if (line_end) begin
            col_d = '0;
            if (!y_last) begin
                yrep_d  = yrep_q + 1'b1;
                state_d = StReplay;
            end else begin
                yrep_d = '0;
                if (r_last) begin
                    row_d   = '0;
                    state_d = StDone;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = StLive;
                end
            end
        end
        // Prefetch the column that follows the one being presented
        raddr = (vld_d && col_d != ColLast) ? col_d + 1'b1 : col_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StLive;
            col_q   <= '0;
            row_q   <= '0;
            xrep_q  <= '0;
            yrep_q  <= '0;
            vld_q   <= 1'b0;
            pix_q   <= '0;
            done_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            xrep_q  <= xrep_d;
            yrep_q  <= yrep_d;
            vld_q   <= vld_d;
            pix_q   <= pix_d;
            done_q  <= (state_d == StDone);
            fcnt_q  <= fcnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (in_hs) linebuf_q[col_d] <= {r, g, b};
        rd_q <= linebuf_q[raddr];
    end

    assign out_valid             = vld_q;
    assign {out_r, out_g, out_b} = pix_q;
    assign out_sol               = vld_q && (col_q == '0) && (xrep_q == '0);
    assign out_eol               = vld_q && eol;
    assign out_eof               = vld_q && eol && y_last && r_last;
    assign done                  = done_q;
    assign frame_cnt             = fcnt_q;

endmodule
